// File: rtl/raster_cmd_scheduler.sv
// Round-robin command scheduler for the 8x8 rasterizer: two requesters feed a small FIFO,
// and commands are issued one at a time, never while a frame is being drawn or streamed.
module raster_cmd_scheduler #(
    parameter int DEPTH        = 4,
    parameter int FRAME_CYCLES = 64,
    parameter int TIMEOUT      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [19:0]              req0_cmd,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [19:0]              req1_cmd,
    output logic                     req1_ready,
    output logic [19:0]              gp_cmd,
    output logic                     gp_command_valid,
    input  logic                     gp_frame_start,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     last_grant,
    output logic                     timeout_err,
    input  logic                     err_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(FRAME_CYCLES);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FS, STREAM} state_t;

    state_t         state, state_nxt;
    logic [19:0]    mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [FW-1:0]  cnt;
    logic [TW-1:0]  timer;
    logic           full, enq, deq, win, timeout_hit;
    logic [19:0]    enq_cmd;

    // Fullness is judged on the registered count, so a pop in this cycle never frees a slot early.
    assign full       = (fifo_count == CW'(DEPTH));
    assign req0_ready = !full && (!req1_valid || last_grant);
    assign req1_ready = !full && (!req0_valid || !last_grant);
    assign win        = !(req0_valid && req0_ready);
    assign enq        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign enq_cmd    = win ? req1_cmd : req0_cmd;
    assign deq        = (state == IDLE) && (fifo_count != '0);
    assign timeout_hit = (state == WAIT_FS) && !gp_frame_start && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            last_grant <= 1'b1;
        end else begin
            if (enq) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= win;
            end
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr] <= enq_cmd;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fifo_count != '0) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT_FS;
            WAIT_FS: begin
                if (gp_frame_start)
                    state_nxt = STREAM;
                else if (timer == TW'(TIMEOUT - 1))
                    state_nxt = IDLE;
            end
            STREAM:  if (cnt == FW'(FRAME_CYCLES - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gp_command_valid = (state == ISSUE);
        busy             = (state != IDLE);
    end

    // Timer runs only while waiting for frame_start; the stream counter restarts on entry to STREAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            gp_cmd      <= '0;
            timer       <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (deq)
                gp_cmd <= mem[rd_ptr];
            if (state == ISSUE)
                timer <= '0;
            else if (state == WAIT_FS)
                timer <= timer + 1'b1;
            if (state == WAIT_FS)
                cnt <= '0;
            else if (state == STREAM)
                cnt <= cnt + 1'b1;
            if (timeout_hit)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_raster_cmd_scheduler.sv
// Scoreboard bench for raster_cmd_scheduler: accepted commands are queued as expected issues,
// and a monitor checks every gp_command_valid strobe against the queue head.
module tb_raster_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [19:0] req0_cmd, req1_cmd;
    logic        req0_ready, req1_ready;
    logic [19:0] gp_cmd;
    logic        gp_command_valid;
    logic        gp_fs;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        last_grant;
    logic        timeout_err;
    logic        err_clr;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          fs_delay;
    logic [19:0] sb [$];

    always #5 clk = ~clk;

    raster_cmd_scheduler #(.DEPTH(4), .FRAME_CYCLES(64), .TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .req0_valid       (req0_valid),
        .req0_cmd         (req0_cmd),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_cmd         (req1_cmd),
        .req1_ready       (req1_ready),
        .gp_cmd           (gp_cmd),
        .gp_command_valid (gp_command_valid),
        .gp_frame_start   (gp_fs),
        .busy             (busy),
        .fifo_count       (fifo_count),
        .last_grant       (last_grant),
        .timeout_err      (timeout_err),
        .err_clr          (err_clr)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && gp_command_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_strobe: got gp_cmd=%h, expected no strobe (t=%0t)", gp_cmd, $time);
                end else begin
                    check("sb_gp_cmd", 32'(gp_cmd), 32'(sb.pop_front()));
                end
            end
        end
    endtask

    // Processor model: raises frame_start fs_delay cycles after the strobe cycle (0 = stalled).
    task automatic gp_model();
        forever begin
            @(negedge clk);
            if (gp_command_valid && fs_delay > 0) begin
                repeat (fs_delay - 1) @(negedge clk);
                @(posedge clk); #1 gp_fs = 1'b1;
                @(posedge clk); #1 gp_fs = 1'b0;
            end
        end
    endtask

    initial begin
        int a0, a1, bc;
        logic [2:0] ec;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_cmd = '0; req1_cmd = '0; gp_fs = 1'b0; err_clr = 1'b0; fs_delay = 0;
        fork
            monitor();
            gp_model();
        join_none

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_gp_cmd",      32'(gp_cmd), 32'h0);
        check("rst_valid",       32'(gp_command_valid), 32'h0);
        check("rst_busy",        32'(busy), 32'h0);
        check("rst_fifo_count",  32'(fifo_count), 32'h0);
        check("rst_last_grant",  32'(last_grant), 32'h1);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);

        // Single command, frame_start two cycles after the strobe.
        fs_delay = 2;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_cmd = 20'h4_6000;
        sb.push_back(20'h4_6000);
        @(negedge clk);
        check("t1_req0_ready", 32'(req0_ready), 32'h1);
        @(posedge clk); #1 req0_valid = 1'b0;
        bc = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy) bc++;
        end
        check("t1_busy_cycles", 32'(bc), 32'd67);
        check("t1_gp_cmd_hold", 32'(gp_cmd), 32'h4_6000);

        // Both requesters saturating a stalled processor: alternation, full, timeouts, reset mid-stream.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        fs_delay = 0;
        a0 = 0; a1 = 0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_cmd = 20'h1_0001; req1_cmd = 20'h2_0001;
        for (int k = 0; k < 74; k++) begin
            @(negedge clk);
            if (k == 0 || k == 2 || k == 4) sb.push_back(req0_cmd);
            if (k == 1 || k == 3 || k == 20) sb.push_back(req1_cmd);
            if (k <= 21) begin
                check("t2_req0_ready", 32'(req0_ready), 32'(k == 0 || k == 2 || k == 4));
                check("t2_req1_ready", 32'(req1_ready), 32'(k == 1 || k == 3 || k == 20));
            end
            if (k == 0)                    ec = 3'd0;
            else if (k <= 2)               ec = 3'd1;
            else if (k == 3)               ec = 3'd2;
            else if (k == 4)               ec = 3'd3;
            else if (k <= 19)              ec = 3'd4;
            else if (k == 20)              ec = 3'd3;
            else if (k <= 37)              ec = 3'd4;
            else if (k <= 72)              ec = 3'd3;
            else                           ec = 3'd0;
            check("t2_fifo_count", 32'(fifo_count), 32'(ec));
            check("t2_strobe", 32'(gp_command_valid), 32'(k == 2 || k == 20 || k == 38));
            check("t2_busy", 32'(busy), 32'(!(k == 0 || k == 1 || k == 19 || k == 37 || k == 73)));
            check("t2_timeout_err", 32'(timeout_err),
                  32'((k >= 19 && k <= 22) || (k >= 37 && k <= 72)));
            if (k == 73) begin
                check("t5_gp_cmd", 32'(gp_cmd), 32'h0);
                check("t5_last_grant", 32'(last_grant), 32'h1);
            end
            @(posedge clk); #1;
            if (k == 0 || k == 2 || k == 4) a0++;
            if (k == 1 || k == 3 || k == 20) a1++;
            req0_cmd   = 20'h1_0001 + 20'(a0);
            req1_cmd   = 20'h2_0001 + 20'(a1);
            req0_valid = (k + 1 <= 21);
            req1_valid = (k + 1 <= 21);
            err_clr    = (k + 1 == 22 || k + 1 == 36);
            gp_fs      = (k + 1 == 41);
            rst        = (k + 1 == 72);
            if (k + 1 == 72) sb.delete();
        end

        bc = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || gp_command_valid) bc++;
        end
        check("t5_no_restart", 32'(bc), 32'h0);

        // frame_start while idle must be ignored.
        @(posedge clk); #1 gp_fs = 1'b1;
        @(posedge clk); #1 gp_fs = 1'b0;
        @(negedge clk);
        check("t6_idle_fs_busy", 32'(busy), 32'h0);
        check("t6_idle_fs_count", 32'(fifo_count), 32'h0);

        // Lone requester 1 wins and is issued normally.
        fs_delay = 1;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_cmd = 20'hA_BCDE;
        sb.push_back(20'hA_BCDE);
        @(negedge clk);
        check("t7_req1_ready", 32'(req1_ready), 32'h1);
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        check("t7_last_grant", 32'(last_grant), 32'h1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        check("end_sb_drained", 32'(sb.size()), 32'h0);
        check("end_busy", 32'(busy), 32'h0);
        check("end_timeout_err", 32'(timeout_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
